fir_filter_tdm: RTL and testbench
=================================

FIR_FILTER_TDM -- requirements
Module: fir_filter_tdm

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, 16, signed sample width.
REQ-002 SHALL have parameter COEFF_WIDTH, 16, signed coefficient width.
REQ-003 SHALL have parameter OUTPUT_WIDTH, 16, signed output width.
REQ-004 SHALL have parameter ACC_WIDTH, 40, signed accumulator width, at least INPUT_WIDTH+COEFF_WIDTH+clog2(NUM_TAPS).
REQ-005 SHALL have parameter NUM_TAPS, 32, taps per channel, 2..256.
REQ-006 SHALL have parameter NUM_CHANNELS, 4, independent channels, 1..16.
REQ-007 SHALL have parameter OUT_SHIFT, 15, arithmetic right shift applied to the accumulator.
REQ-008 SHALL have parameter ROUND, 1, 1 = round half-up at the shift, 0 = truncate.
REQ-009 SHALL have parameter SATURATE, 1, 1 = clamp to OUTPUT_WIDTH, 0 = wrap.
REQ-010 SHALL have parameter COEFFS_INIT, COEFF_WIDTH x NUM_TAPS array, reset coefficients, default impulse (tap0=1, others 0).
REQ-011 SHALL have ports, clock and reset first: clk in 1 clock; rst in 1 asynchronous active-high reset; in_valid in 1; in_ready out 1; in_chan in clog2(NUM_CHANNELS); din in INPUT_WIDTH; out_valid out 1; out_ready in 1; out_chan out clog2(NUM_CHANNELS); dout out OUTPUT_WIDTH; out_sat out 1 (dout clamped); coeff_we in 1; coeff_addr in clog2(NUM_TAPS); coeff_data in COEFF_WIDTH; coeff_err out 1 (write rejected pulse); chan_err out 1 (bad-channel pulse).
REQ-012 SHALL use one clock, clk; rst SHALL be asynchronous and active-high.

Function
REQ-013 SHALL keep per channel a circular delay line of NUM_TAPS samples and a write pointer; all channels SHALL share one coefficient set and one multiplier.
REQ-014 SHALL implement FSM IDLE -> MAC -> FLUSH -> OUT -> IDLE.
REQ-015 in_ready SHALL be 1 only in IDLE; a sample is accepted on an edge with in_valid & in_ready.
REQ-016 On acceptance with in_chan < NUM_CHANNELS: write din at that channel's pointer, advance the pointer modulo NUM_TAPS (wrap NUM_TAPS-1 -> 0), latch the channel, clear the accumulator, enter MAC.
REQ-017 On acceptance with in_chan >= NUM_CHANNELS: drop the sample, pulse chan_err for one cycle, stay in IDLE.
REQ-018 MAC SHALL last exactly NUM_TAPS cycles, step k forming coeff[k]*x[n-k] with x[n] the newest sample, into a 1-stage registered multiplier.
REQ-019 FLUSH SHALL last 1 cycle, adding the last product.
REQ-020 Output SHALL be y = (acc + (ROUND ? 2^(OUT_SHIFT-1) : 0)) >>> OUT_SHIFT; with OUT_SHIFT=0 no rounding term is added.
REQ-021 If SATURATE=1 and y is outside the OUTPUT_WIDTH range, dout SHALL be the nearest limit and out_sat=1; otherwise dout = y[OUTPUT_WIDTH-1:0] and out_sat=0.
REQ-022 out_valid SHALL rise exactly NUM_TAPS+2 cycles after the accepting edge; dout, out_chan and out_sat SHALL stay stable while out_valid=1.
REQ-023 OUT SHALL hold until out_valid & out_ready, then go to IDLE; in_ready is 1 the next cycle, giving a minimum of NUM_TAPS+3 cycles per sample.
REQ-024 coeff_we SHALL write coeff[coeff_addr] only in IDLE; in any other state the write SHALL be ignored and coeff_err pulse for 1 cycle.
REQ-025 A coefficient write and a sample acceptance on the same IDLE edge SHALL both occur; that sample's MAC SHALL use the new coefficient.
REQ-026 The accumulator SHALL wrap modulo 2^ACC_WIDTH without a flag.

Reset
REQ-027 While rst=1: state=IDLE, in_ready=0, out_valid=0, dout=0, out_chan=0, out_sat=0, coeff_err=0, chan_err=0, all delay lines and pointers 0, coefficients = COEFFS_INIT.
REQ-028 in_ready SHALL rise on the first clk edge after rst deasserts.
REQ-029 Reset mid-MAC or in OUT SHALL abort the computation with no out_valid and no partial result.

Verification (NUM_TAPS=4, NUM_CHANNELS=2, OUT_SHIFT=0, widths 16/16/16/40)
REQ-030 Coeffs {1,2,3,4}, ch0 samples 100,0,0,0,0, out_ready=1 -> dout 100,200,300,400,0, each NUM_TAPS+2=6 cycles after its accepting edge.
REQ-031 Interleave ch0=100 then ch1=7, then zeros on both -> ch0 outputs are unaffected by ch1, ch1 outputs are 7,14,21,28, and out_chan matches each output.
REQ-032 All coeffs 32767, ch0 fed 32767 four times -> dout=32767, out_sat=1; with SATURATE=0 -> dout = low 16 bits of 4*32767^2.
REQ-033 out_ready held 0 for 10 cycles in OUT -> out_valid and dout stable and in_ready=0 throughout; then 1 cycle with out_ready=1 -> IDLE.
REQ-034 coeff_we during MAC -> coeff_err pulse and the next impulse response unchanged; coeff_we with in_valid in IDLE -> the new coefficient is used.
REQ-035 rst asserted in MAC step 2 -> no out_valid, and an impulse after release gives COEFFS_INIT response 1,0,0,0.

Source files
------------

// File: rtl/fir_filter_tdm.sv
// Time-division multiplexed FIR filter: NUM_CHANNELS independent delay lines
// share one coefficient set and one registered multiplier, one tap per cycle.
module fir_filter_tdm #(
   parameter int INPUT_WIDTH  = 16,
   parameter int COEFF_WIDTH  = 16,
   parameter int OUTPUT_WIDTH = 16,
   parameter int ACC_WIDTH    = 40,
   parameter int NUM_TAPS     = 32,
   parameter int NUM_CHANNELS = 4,
   parameter int OUT_SHIFT    = 15,
   parameter int ROUND        = 1,
   parameter int SATURATE     = 1,
   parameter logic [NUM_TAPS-1:0][COEFF_WIDTH-1:0] COEFFS_INIT = (NUM_TAPS*COEFF_WIDTH)'(1),
   localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
   localparam int TAP_W = $clog2(NUM_TAPS)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [CH_W-1:0]                in_chan,
   input  logic signed [INPUT_WIDTH-1:0]  din,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [CH_W-1:0]                out_chan,
   output logic signed [OUTPUT_WIDTH-1:0] dout,
   output logic                           out_sat,
   input  logic                           coeff_we,
   input  logic [TAP_W-1:0]               coeff_addr,
   input  logic signed [COEFF_WIDTH-1:0]  coeff_data,
   output logic                           coeff_err,
   output logic                           chan_err,
   output logic [1:0]                     dbg_state
);

   localparam int PW = INPUT_WIDTH + COEFF_WIDTH;
   localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
   localparam logic signed [ACC_WIDTH:0] W_ONE = 1;
   localparam logic signed [ACC_WIDTH:0] ROUND_TERM =
      ((ROUND != 0) && (OUT_SHIFT > 0)) ? (W_ONE <<< RND_SH) : '0;
   localparam logic signed [ACC_WIDTH:0] OUT_MAX = (W_ONE <<< (OUTPUT_WIDTH - 1)) - W_ONE;
   localparam logic signed [ACC_WIDTH:0] OUT_MIN = -(W_ONE <<< (OUTPUT_WIDTH - 1));
   localparam logic [TAP_W:0] N_EXT = (TAP_W + 1)'(NUM_TAPS);
   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_MAC   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_OUT   = 2'd3;

   logic [1:0]                     r_state;
   logic                           r_live;
   logic [TAP_W-1:0]               r_step;
   logic [TAP_W-1:0]               r_base;
   logic [CH_W-1:0]                r_chan;
   logic [TAP_W-1:0]               r_ptr   [NUM_CHANNELS];
   logic signed [INPUT_WIDTH-1:0]  r_dline [NUM_CHANNELS][NUM_TAPS];
   logic signed [COEFF_WIDTH-1:0]  r_coeff [NUM_TAPS];
   logic signed [PW-1:0]           r_prod;
   logic                           r_prod_v;
   logic signed [ACC_WIDTH-1:0]    r_acc;
   logic                           r_out_valid;
   logic signed [OUTPUT_WIDTH-1:0] r_dout;
   logic [CH_W-1:0]                r_out_chan;
   logic                           r_out_sat;
   logic                           r_coeff_err;
   logic                           r_chan_err;

   logic                           w_accept;
   logic                           w_chan_ok;
   logic                           w_addr_ok;
   logic [TAP_W:0]                 w_idx_sum;
   logic [TAP_W-1:0]               w_tap;
   logic signed [INPUT_WIDTH-1:0]  w_sample;
   logic signed [COEFF_WIDTH-1:0]  w_coeff;
   logic signed [PW-1:0]           w_prod;
   logic signed [ACC_WIDTH-1:0]    w_prod_ext;
   logic signed [ACC_WIDTH:0]      w_rsum;
   logic signed [ACC_WIDTH:0]      w_y;
   logic                           w_hi;
   logic                           w_lo;

   // Input handshake: a sample transfers on a rising edge where in_valid && in_ready;
   // output transfers on a rising edge where out_valid && out_ready. Offered data
   // and valid must hold until the transfer; out_* hold stable while out_valid=1.
   assign w_accept = in_valid && in_ready;
   assign in_ready = r_live && (r_state == S_IDLE);

   generate
      if ((2 ** CH_W) > NUM_CHANNELS) begin : g_chan_chk
         assign w_chan_ok = (in_chan < CH_W'(NUM_CHANNELS));
      end else begin : g_chan_all
         assign w_chan_ok = 1'b1;
      end
      if ((2 ** TAP_W) > NUM_TAPS) begin : g_addr_chk
         assign w_addr_ok = (coeff_addr < TAP_W'(NUM_TAPS));
      end else begin : g_addr_all
         assign w_addr_ok = 1'b1;
      end
   endgenerate

   // Step k reads x[n-k]: newest sample sits at r_base, older ones walk backwards.
   assign w_idx_sum = {1'b0, r_base} + N_EXT - {1'b0, r_step};
   assign w_tap     = TAP_W'((w_idx_sum >= N_EXT) ? (w_idx_sum - N_EXT) : w_idx_sum);
   assign w_sample  = r_dline[r_chan][w_tap];
   assign w_coeff   = r_coeff[r_step];
   assign w_prod    = $signed({{COEFF_WIDTH{w_sample[INPUT_WIDTH-1]}}, w_sample}) *
                      $signed({{INPUT_WIDTH{w_coeff[COEFF_WIDTH-1]}}, w_coeff});
   assign w_prod_ext = {{(ACC_WIDTH - PW){r_prod[PW-1]}}, r_prod};

   assign w_rsum = {r_acc[ACC_WIDTH-1], r_acc} + ROUND_TERM;
   assign w_y    = w_rsum >>> OUT_SHIFT;
   assign w_hi   = (SATURATE != 0) && (w_y > OUT_MAX);
   assign w_lo   = (SATURATE != 0) && (w_y < OUT_MIN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_live      <= 1'b0;
         r_step      <= '0;
         r_base      <= '0;
         r_chan      <= '0;
         r_prod      <= '0;
         r_prod_v    <= 1'b0;
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_dout      <= '0;
         r_out_chan  <= '0;
         r_out_sat   <= 1'b0;
         r_coeff_err <= 1'b0;
         r_chan_err  <= 1'b0;
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            r_ptr[c] <= '0;
            for (int t = 0; t < NUM_TAPS; t++) begin
               r_dline[c][t] <= '0;
            end
         end
         for (int t = 0; t < NUM_TAPS; t++) begin
            r_coeff[t] <= COEFFS_INIT[t];
         end
      end else begin
         r_live      <= 1'b1;
         r_coeff_err <= 1'b0;
         r_chan_err  <= 1'b0;

         if (coeff_we) begin
            if (r_state == S_IDLE) begin
               if (w_addr_ok) begin
                  r_coeff[coeff_addr] <= coeff_data;
               end
            end else begin
               r_coeff_err <= 1'b1;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_chan_ok) begin
                     r_dline[in_chan][r_ptr[in_chan]] <= din;
                     r_ptr[in_chan] <= (r_ptr[in_chan] == LAST_TAP) ? '0 : r_ptr[in_chan] + 1'b1;
                     r_base   <= r_ptr[in_chan];
                     r_chan   <= in_chan;
                     r_acc    <= '0;
                     r_prod_v <= 1'b0;
                     r_step   <= '0;
                     r_state  <= S_MAC;
                  end else begin
                     r_chan_err <= 1'b1;
                  end
               end
            end
            S_MAC: begin
               r_prod   <= w_prod;
               r_prod_v <= 1'b1;
               if (r_prod_v) begin
                  r_acc <= r_acc + w_prod_ext;
               end
               if (r_step == LAST_TAP) begin
                  r_state <= S_FLUSH;
               end else begin
                  r_step <= r_step + 1'b1;
               end
            end
            S_FLUSH: begin
               r_acc   <= r_acc + w_prod_ext;
               r_state <= S_OUT;
            end
            default: begin
               // First OUT cycle registers the scaled result; it then holds for the consumer.
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
                  r_out_chan  <= r_chan;
                  r_out_sat   <= w_hi || w_lo;
                  r_dout      <= w_hi ? OUT_MAX[OUTPUT_WIDTH-1:0] :
                                 w_lo ? OUT_MIN[OUTPUT_WIDTH-1:0] : w_y[OUTPUT_WIDTH-1:0];
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign dout      = r_dout;
   assign out_chan  = r_out_chan;
   assign out_sat   = r_out_sat;
   assign coeff_err = r_coeff_err;
   assign chan_err  = r_chan_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_fir_filter_tdm.sv
// Bench for fir_filter_tdm: 4 taps, 2 channels, unity scaling; a saturating and a
// wrapping instance run in lockstep against a direct-form convolution model.
module tb_fir_filter_tdm;

   localparam int NT = 4;
   localparam int NC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_chan;
   logic [15:0] din;
   logic        out_ready;
   logic        coeff_we;
   logic [1:0]  coeff_addr;
   logic [15:0] coeff_data;

   logic        in_ready, out_valid, out_chan, out_sat, coeff_err, chan_err;
   logic [15:0] dout;
   logic [1:0]  dbg_state;
   logic        in_ready2, out_valid2, out_chan2, out_sat2, coeff_err2, chan_err2;
   logic [15:0] dout2;
   logic [1:0]  dbg_state2;

   int     n_checks = 0;
   int     n_pass = 0;
   int     n_fail = 0;
   longint coef [NT];
   longint hist [NC][NT];

   always #5 clk = ~clk;

   fir_filter_tdm #(
      .INPUT_WIDTH(16), .COEFF_WIDTH(16), .OUTPUT_WIDTH(16), .ACC_WIDTH(40),
      .NUM_TAPS(NT), .NUM_CHANNELS(NC), .OUT_SHIFT(0), .ROUND(1), .SATURATE(1)
   ) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan),
      .din(din), .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
      .dout(dout), .out_sat(out_sat), .coeff_we(coeff_we), .coeff_addr(coeff_addr),
      .coeff_data(coeff_data), .coeff_err(coeff_err), .chan_err(chan_err),
      .dbg_state(dbg_state)
   );

   fir_filter_tdm #(
      .INPUT_WIDTH(16), .COEFF_WIDTH(16), .OUTPUT_WIDTH(16), .ACC_WIDTH(40),
      .NUM_TAPS(NT), .NUM_CHANNELS(NC), .OUT_SHIFT(0), .ROUND(1), .SATURATE(0)
   ) dut_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_chan(in_chan),
      .din(din), .out_valid(out_valid2), .out_ready(out_ready), .out_chan(out_chan2),
      .dout(dout2), .out_sat(out_sat2), .coeff_we(coeff_we), .coeff_addr(coeff_addr),
      .coeff_data(coeff_data), .coeff_err(coeff_err2), .chan_err(chan_err2),
      .dbg_state(dbg_state2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < NT; k++) begin
         coef[k] = (k == 0) ? 1 : 0;
         for (int c = 0; c < NC; c++) hist[c][k] = 0;
      end
   endfunction

   function automatic void model_push(input int ch, input int val);
      for (int k = NT - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
      hist[ch][0] = val;
   endfunction

   // y = sum coeff[k]*x[n-k], wrapped to 40 bits, then clamped or truncated to 16 bits.
   function automatic logic [16:0] model_out(input int ch, input bit sat);
      longint acc = 0;
      for (int k = 0; k < NT; k++) acc += coef[k] * hist[ch][k];
      acc = (acc <<< 24) >>> 24;
      if (sat && acc > 32767) return {1'b1, 16'h7fff};
      if (sat && acc < -32768) return {1'b1, 16'h8000};
      return {1'b0, acc[15:0]};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      coeff_we = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_dout", dout, 0);
      check("rst_out_chan", out_chan, 0);
      check("rst_out_sat", out_sat, 0);
      check("rst_coeff_err", coeff_err, 0);
      check("rst_chan_err", chan_err, 0);
      check("rst_state", dbg_state, 0);
      rst = 1'b0;
      model_reset();
      #1 check("rel_in_ready_low", in_ready, 0);
      @(negedge clk);
      check("rel_in_ready_high", in_ready, 1);
   endtask

   task automatic write_coeff(input int addr, input int data);
      coeff_we = 1'b1;
      coeff_addr = addr[1:0];
      coeff_data = data[15:0];
      @(posedge clk);
      coef[addr] = data;
      @(negedge clk);
      coeff_we = 1'b0;
      check("idle_coeff_err", coeff_err, 0);
   endtask

   // One sample end to end: accept, optional write during MAC, latency, result, handshake.
   task automatic run_sample(input int ch, input int val, input bit cw, input int caddr,
                             input int cdata, input int hold, input bit mid_we);
      int waitc;
      int lat;
      logic [16:0] e1;
      logic [16:0] e2;
      waitc = 0;
      while (!in_ready && waitc < 100) begin
         @(negedge clk);
         waitc++;
      end
      check("in_ready_wait", in_ready, 1);
      in_valid = 1'b1;
      in_chan = ch[0];
      din = val[15:0];
      if (cw) begin
         coeff_we = 1'b1;
         coeff_addr = caddr[1:0];
         coeff_data = cdata[15:0];
      end
      out_ready = (hold == 0);
      @(posedge clk);
      if (cw) coef[caddr] = cdata;
      model_push(ch, val);
      @(negedge clk);
      in_valid = 1'b0;
      coeff_we = 1'b0;
      check("busy_in_ready", in_ready, 0);
      lat = 0;
      if (mid_we) begin
         @(negedge clk);
         lat++;
         coeff_we = 1'b1;
         coeff_addr = 2'd0;
         coeff_data = 16'h0063;
         @(negedge clk);
         lat++;
         coeff_we = 1'b0;
         check("mac_coeff_err_pulse", coeff_err, 1);
         @(negedge clk);
         lat++;
         check("mac_coeff_err_clear", coeff_err, 0);
      end
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, NT + 2);
      e1 = model_out(ch, 1'b1);
      e2 = model_out(ch, 1'b0);
      check("dout", dout, e1[15:0]);
      check("out_sat", out_sat, e1[16]);
      check("out_chan", out_chan, ch);
      check("wrap_valid", out_valid2, 1);
      check("wrap_dout", dout2, e2[15:0]);
      check("wrap_out_sat", out_sat2, e2[16]);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_dout", dout, e1[15:0]);
         check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("done_valid", out_valid, 0);
      check("done_in_ready", in_ready, 1);
   endtask

   initial begin
      int ch;
      int val;
      logic [15:0] r16;
      bit saw_valid;

      in_chan = 1'b0;
      din = '0;
      coeff_addr = '0;
      coeff_data = '0;
      do_reset();

      // Impulse through coefficients 1..4 on channel 0.
      for (int k = 0; k < NT; k++) write_coeff(k, k + 1);
      run_sample(0, 100, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) run_sample(0, 0, 0, 0, 0, 0, 0);

      // Interleaved channels must stay independent.
      run_sample(0, 100, 0, 0, 0, 0, 0);
      run_sample(1, 7, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         run_sample(0, 0, 0, 0, 0, 0, 0);
         run_sample(1, 0, 0, 0, 0, 0, 0);
      end

      // Back-pressure for 10 cycles in OUT.
      run_sample(1, -1234, 0, 0, 0, 10, 0);

      // Write during MAC is rejected; write alongside an accepted sample takes effect.
      run_sample(0, 1000, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) run_sample(0, 0, 0, 0, 0, 0, 0);
      run_sample(0, 50, 1, 0, 5, 0, 0);

      // Overflow: saturate in one instance, wrap in the other.
      for (int k = 0; k < NT; k++) write_coeff(k, 32767);
      for (int i = 0; i < 4; i++) run_sample(0, 32767, 0, 0, 0, 0, 0);
      check("wrap_4x_max_sq", dout2, 16'h0004);
      check("sat_4x_max_sq", dout, 16'h7fff);

      // Randomised traffic, including coefficient updates on accepting edges.
      for (int i = 0; i < 24; i++) begin
         ch = $urandom_range(0, NC - 1);
         r16 = 16'($urandom);
         val = int'($signed(r16));
         r16 = 16'($urandom);
         run_sample(ch, val, ($urandom_range(0, 3) == 0), $urandom_range(0, NT - 1),
                    int'($signed(r16)), $urandom_range(0, 1) * 3, 0);
      end

      // Reset during MAC step 2 aborts the computation.
      in_valid = 1'b1;
      in_chan = 1'b0;
      din = 16'd500;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("pre_abort_state_mac", dbg_state, 1);
      rst = 1'b1;
      #1 check("abort_state_idle", dbg_state, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      saw_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid || out_valid2) saw_valid = 1'b1;
      end
      check("abort_no_out_valid", saw_valid, 0);
      run_sample(0, 1, 0, 0, 0, 0, 0);
      check("init_resp_0", dout, 16'd1);
      for (int i = 1; i < NT; i++) begin
         run_sample(0, 0, 0, 0, 0, 0, 0);
         check("init_resp_tail", dout, 16'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
